reg_file_param: RTL

Parametrised register file: DEPTH registers of WIDTH bits, one write port with four write modes (load, increment, shift-left, clear), two independent combinational read ports, and registered carry/error status flags. It is the general-purpose register storage for the CPU datapath. It replaces fixed-width single registers built from discrete D flip-flops with one configurable bank.

---
 rtl/reg_file_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parametrised register bank: one modify-capable write port on the falling edge,
// two combinational read ports, and registered carry/error flags.
module reg_file_param #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              inClk,
    input  logic              inClr,
    input  logic              inWrEn,
    input  logic [ADDR_W-1:0] inWrAddr,
    input  logic [1:0]        inWrMode,
    input  logic [WIDTH-1:0]  inWrData,
    input  logic [ADDR_W-1:0] inRdAddrA,
    input  logic [ADDR_W-1:0] inRdAddrB,
    output logic [WIDTH-1:0]  outRdDataA,
    output logic [WIDTH-1:0]  outRdDataB,
    output logic              outCarry,
    output logic              outErr
);

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_INC  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_CLR  = 2'b11
    } wr_mode_e;

    localparam logic [ADDR_W:0] DEPTH_EXT = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             carry_q;
    logic             err_q;

    logic             addr_ok;
    logic             zero_hit;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] new_val_d;
    logic             carry_d;
    logic             err_d;

    always_comb begin
        addr_ok   = ({1'b0, inWrAddr} < DEPTH_EXT);
        zero_hit  = (ZERO_REG != 0) && (inWrAddr == '0);
        // A hardwired zero register feeds 0 into the flag logic, not its stored value.
        old_val   = (addr_ok && !zero_hit) ? regs_q[inWrAddr] : '0;
        inc_sum   = {1'b0, old_val} + 1'b1;
        new_val_d = old_val;
        carry_d   = 1'b0;
        err_d     = 1'b0;
        case (wr_mode_e'(inWrMode))
            MODE_LOAD: new_val_d = inWrData;
            MODE_INC: begin
                new_val_d = inc_sum[WIDTH-1:0];
                carry_d   = inc_sum[WIDTH];
            end
            MODE_SHL: begin
                new_val_d = {old_val[WIDTH-2:0], 1'b0};
                carry_d   = old_val[WIDTH-1];
            end
            MODE_CLR: new_val_d = '0;
            default:  new_val_d = old_val;
        endcase
        if (!addr_ok) begin
            err_d   = 1'b1;
            carry_d = 1'b0;
        end
    end

    always_ff @(negedge inClk or posedge inClr) begin
        if (inClr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (inWrEn) begin
            carry_q <= carry_d;
            err_q   <= err_d;
            if (addr_ok && !zero_hit) begin
                regs_q[inWrAddr] <= new_val_d;
            end
        end
    end

    always_comb begin
        outRdDataA = '0;
        outRdDataB = '0;
        if ({1'b0, inRdAddrA} < DEPTH_EXT) begin
            outRdDataA = regs_q[inRdAddrA];
        end
        if ({1'b0, inRdAddrB} < DEPTH_EXT) begin
            outRdDataB = regs_q[inRdAddrB];
        end
    end

    assign outCarry = carry_q;
    assign outErr   = err_q;

endmodule
